// File: rtl/pcm_engine_arbiter.sv
// pcm_engine_arbiter: round-robin share of one PCM engine between two single-slot requesters
// Build option: define PCM_ARB_TIMEOUT_EN to enable the WAIT watchdog (TIMEOUT cycles).
// Ports:
//   clk_fast              sole clock
//   rst                   synchronous active-high reset
//   req0_valid/req0_data  channel 0 sample pulse and data
//   req1_valid/req1_data  channel 1 sample pulse and data
//   eng_start             one-cycle engine launch pulse
//   eng_data/eng_chan     sample and owner, held for the whole transaction
//   eng_done/eng_result   engine completion pulse and result
//   res0_valid/res1_valid per-channel result pulse
//   res_data              registered result, held until the next result
//   ovf                   sticky per-channel slot overflow flags
//   timeout               one-cycle abort pulse (watchdog builds only)
//   busy                  high whenever the FSM is not IDLE
module pcm_engine_arbiter #(
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 255
) (
    input  logic              clk_fast,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [DATA_W-1:0] req0_data,
    input  logic              req1_valid,
    input  logic [DATA_W-1:0] req1_data,
    output logic              eng_start,
    output logic [DATA_W-1:0] eng_data,
    output logic              eng_chan,
    input  logic              eng_done,
    input  logic [DATA_W-1:0] eng_result,
    output logic              res0_valid,
    output logic              res1_valid,
    output logic [DATA_W-1:0] res_data,
    output logic [1:0]        ovf,
    output logic              timeout,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t            state, state_nx;
    logic              pend0, pend1, last_grant;
    logic [DATA_W-1:0] slot0, slot1;
    logic              grant0, grant1, done_ok, expire;

    if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("pcm_engine_arbiter: TIMEOUT must be 1..65535");
    end

    always_ff @(posedge clk_fast) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Ties go to the channel that did not win last time.
    always_comb begin
        grant0   = (state == IDLE) && pend0 && (!pend1 || last_grant);
        grant1   = (state == IDLE) && pend1 && (!pend0 || !last_grant);
        done_ok  = (state == WAIT) && eng_done;
        state_nx = (state == IDLE)  ? ((grant0 || grant1) ? ISSUE : IDLE) :
                   (state == ISSUE) ? WAIT :
                   (done_ok || expire) ? IDLE : WAIT;
    end

    assign eng_start = (state == ISSUE);
    assign busy      = (state != IDLE);

    // A request landing in the grant cycle refills the slot instead of overflowing it.
    always_ff @(posedge clk_fast) begin
        if (rst) begin
            pend0      <= 1'b0;
            pend1      <= 1'b0;
            slot0      <= '0;
            slot1      <= '0;
            last_grant <= 1'b1;
            eng_data   <= '0;
            eng_chan   <= 1'b0;
            res0_valid <= 1'b0;
            res1_valid <= 1'b0;
            res_data   <= '0;
            ovf        <= 2'b00;
        end else begin
            pend0      <= req0_valid || (pend0 && !grant0);
            pend1      <= req1_valid || (pend1 && !grant1);
            slot0      <= req0_valid ? req0_data : slot0;
            slot1      <= req1_valid ? req1_data : slot1;
            ovf[0]     <= ovf[0] || (req0_valid && pend0 && !grant0);
            ovf[1]     <= ovf[1] || (req1_valid && pend1 && !grant1);
            if (grant0 || grant1) begin
                eng_data   <= grant1 ? slot1 : slot0;
                eng_chan   <= grant1;
                last_grant <= grant1;
            end
            res0_valid <= done_ok && !eng_chan;
            res1_valid <= done_ok && eng_chan;
            if (done_ok) res_data <= eng_result;
        end
    end

`ifdef PCM_ARB_TIMEOUT_EN
    logic [15:0] wd_cnt;

    // Counter is 0 in the first WAIT cycle, so expiry after TIMEOUT WAIT cycles; done wins a tie.
    assign expire = (state == WAIT) && !eng_done && (wd_cnt == 16'(TIMEOUT - 1));

    always_ff @(posedge clk_fast) begin
        if (rst) begin
            wd_cnt  <= '0;
            timeout <= 1'b0;
        end else begin
            wd_cnt  <= (state == WAIT) ? wd_cnt + 16'd1 : '0;
            timeout <= expire;
        end
    end
`else
    assign expire  = 1'b0;
    assign timeout = 1'b0;
`endif
endmodule

// File: tb/tb_pcm_engine_arbiter.sv
// tb_pcm_engine_arbiter: table-driven per-cycle check of pcm_engine_arbiter plus long-WAIT sequence
module tb_pcm_engine_arbiter;
    logic        clk_fast = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid = 1'b0, req1_valid = 1'b0, eng_done = 1'b0;
    logic [15:0] req0_data = '0, req1_data = '0, eng_result = '0;
    logic        eng_start, eng_chan, res0_valid, res1_valid, timeout, busy;
    logic [15:0] eng_data, res_data;
    logic [1:0]  ovf;
    int          n_cmp = 0, n_bad = 0;

    pcm_engine_arbiter #(.DATA_W(16), .TIMEOUT(8)) dut (
        .clk_fast(clk_fast), .rst(rst),
        .req0_valid(req0_valid), .req0_data(req0_data),
        .req1_valid(req1_valid), .req1_data(req1_data),
        .eng_start(eng_start), .eng_data(eng_data), .eng_chan(eng_chan),
        .eng_done(eng_done), .eng_result(eng_result),
        .res0_valid(res0_valid), .res1_valid(res1_valid), .res_data(res_data),
        .ovf(ovf), .timeout(timeout), .busy(busy)
    );

    always #5 clk_fast = ~clk_fast;

    typedef struct {
        logic rst; logic r0v; logic [15:0] r0d; logic r1v; logic [15:0] r1d; logic dn; logic [15:0] dr;
        logic st; logic [15:0] ed; logic ec; logic v0; logic v1; logic [15:0] rd; logic [1:0] ov; logic bs;
    } row_t;

    row_t tbl[$];

    function automatic row_t mk(logic r, logic a, logic [15:0] ad, logic b, logic [15:0] bd, logic d,
                                logic [15:0] dd, logic st, logic [15:0] ed, logic ec, logic v0,
                                logic v1, logic [15:0] rd, logic [1:0] ov, logic bs);
        mk = '{r, a, ad, b, bd, d, dd, st, ed, ec, v0, v1, rd, ov, bs};
    endfunction

    task automatic chk(string nm, logic [39:0] act, logic [39:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic next();
        @(posedge clk_fast);
        #1;
        rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; eng_done = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got hang expected finish");
        $fatal(1, "hang");
    end

    initial begin
        //            rst r0v r0d      r1v r1d      dn dr       st ed       ec v0 v1 rd       ov bs
        tbl.push_back(mk(0, 1, 16'h1234, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 0));
        tbl.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 0));
        tbl.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 1, 16'h1234, 0, 0, 0, 16'h0000, 0, 1));
        tbl.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0AAA, 0, 16'h1234, 0, 0, 0, 16'h0000, 0, 1));
        tbl.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 16'h1234, 0, 1, 0, 16'h0AAA, 0, 0));
        tbl.push_back(mk(0, 1, 16'h0003, 1, 16'h0004, 0, 16'h0000, 0, 16'h1234, 0, 0, 0, 16'h0AAA, 0, 0));
        tbl.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 16'h1234, 0, 0, 0, 16'h0AAA, 0, 0));
        tbl.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 1, 16'h0004, 1, 0, 0, 16'h0AAA, 0, 1));
        tbl.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0400, 0, 16'h0004, 1, 0, 0, 16'h0AAA, 0, 1));
        tbl.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 16'h0004, 1, 0, 1, 16'h0400, 0, 0));
        tbl.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 1, 16'h0003, 0, 0, 0, 16'h0400, 0, 1));
        tbl.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0300, 0, 16'h0003, 0, 0, 0, 16'h0400, 0, 1));
        tbl.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 16'h0003, 0, 1, 0, 16'h0300, 0, 0));
        tbl.push_back(mk(1, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 16'h0003, 0, 0, 0, 16'h0300, 0, 0));
        tbl.push_back(mk(0, 1, 16'h0001, 1, 16'h0002, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 0));
        tbl.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 0));
        tbl.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 1, 16'h0001, 0, 0, 0, 16'h0000, 0, 1));
        tbl.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0100, 0, 16'h0001, 0, 0, 0, 16'h0000, 0, 1));
        tbl.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 16'h0001, 0, 1, 0, 16'h0100, 0, 0));
        tbl.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 1, 16'h0002, 1, 0, 0, 16'h0100, 0, 1));
        tbl.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0200, 0, 16'h0002, 1, 0, 0, 16'h0100, 0, 1));
        tbl.push_back(mk(0, 1, 16'h0005, 0, 16'h0000, 0, 16'h0000, 0, 16'h0002, 1, 0, 1, 16'h0200, 0, 0));
        tbl.push_back(mk(0, 0, 16'h0000, 1, 16'h1111, 0, 16'h0000, 0, 16'h0002, 1, 0, 0, 16'h0200, 0, 0));
        tbl.push_back(mk(0, 0, 16'h0000, 1, 16'h2222, 0, 16'h0000, 1, 16'h0005, 0, 0, 0, 16'h0200, 0, 1));
        tbl.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0500, 0, 16'h0005, 0, 0, 0, 16'h0200, 2, 1));
        tbl.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 16'h0005, 0, 1, 0, 16'h0500, 2, 0));
        tbl.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 1, 16'h2222, 1, 0, 0, 16'h0500, 2, 1));
        tbl.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 1, 16'h2200, 0, 16'h2222, 1, 0, 0, 16'h0500, 2, 1));
        tbl.push_back(mk(0, 1, 16'h0007, 0, 16'h0000, 0, 16'h0000, 0, 16'h2222, 1, 0, 1, 16'h2200, 2, 0));
        tbl.push_back(mk(0, 1, 16'h0008, 0, 16'h0000, 0, 16'h0000, 0, 16'h2222, 1, 0, 0, 16'h2200, 2, 0));
        tbl.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 1, 16'h0007, 0, 0, 0, 16'h2200, 2, 1));
        tbl.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0070, 0, 16'h0007, 0, 0, 0, 16'h2200, 2, 1));
        tbl.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 16'h0007, 0, 1, 0, 16'h0070, 2, 0));
        tbl.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 1, 16'h7FFF, 1, 16'h0008, 0, 0, 0, 16'h0070, 2, 1));
        tbl.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0080, 0, 16'h0008, 0, 0, 0, 16'h0070, 2, 1));
        tbl.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 16'h0008, 0, 1, 0, 16'h0080, 2, 0));
        tbl.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 1, 16'h1357, 0, 16'h0008, 0, 0, 0, 16'h0080, 2, 0));
        tbl.push_back(mk(0, 1, 16'h0009, 0, 16'h0000, 0, 16'h0000, 0, 16'h0008, 0, 0, 0, 16'h0080, 2, 0));
        tbl.push_back(mk(0, 0, 16'h0000, 1, 16'h000A, 0, 16'h0000, 0, 16'h0008, 0, 0, 0, 16'h0080, 2, 0));
        tbl.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 1, 16'h0009, 0, 0, 0, 16'h0080, 2, 1));
        tbl.push_back(mk(1, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 16'h0009, 0, 0, 0, 16'h0080, 2, 1));
        tbl.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 0));
        tbl.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 0));
        tbl.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 1, 16'hBEEF, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 0));
        tbl.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 0));
        tbl.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 0));

        rst = 1'b1;
        @(posedge clk_fast);
        @(posedge clk_fast);
        #1;
        foreach (tbl[i]) begin
            rst = tbl[i].rst;
            req0_valid = tbl[i].r0v; req0_data = tbl[i].r0d;
            req1_valid = tbl[i].r1v; req1_data = tbl[i].r1d;
            eng_done = tbl[i].dn; eng_result = tbl[i].dr;
            @(negedge clk_fast);
            chk($sformatf("row%0d {start,data,chan,res0,res1,rdata,ovf,timeout,busy}", i),
                {eng_start, eng_data, eng_chan, res0_valid, res1_valid, res_data, ovf, timeout, busy},
                {tbl[i].st, tbl[i].ed, tbl[i].ec, tbl[i].v0, tbl[i].v1, tbl[i].rd, tbl[i].ov, 1'b0, tbl[i].bs});
            next();
        end

        // Long WAIT with ch0 queued behind ch1.
        req1_valid = 1'b1; req1_data = 16'h0C0C;
        next();
        req0_valid = 1'b1; req0_data = 16'h0D0D;
        next();
        @(negedge clk_fast);
        chk("long_start_ch1 {start,chan,data}", 40'({eng_start, eng_chan, eng_data}), 40'({1'b1, 1'b1, 16'h0C0C}));
        next();
`ifdef PCM_ARB_TIMEOUT_EN
        for (int k = 0; k < 8; k++) begin
            @(negedge clk_fast);
            chk($sformatf("wd_wait%0d {busy,timeout,res0,res1,start}", k),
                40'({busy, timeout, res0_valid, res1_valid, eng_start}), 40'(5'b10000));
            next();
        end
        @(negedge clk_fast);
        chk("wd_expire {timeout,busy,res0,res1}", 40'({timeout, busy, res0_valid, res1_valid}), 40'(4'b1000));
        next();
        @(negedge clk_fast);
        chk("wd_next_start {start,chan,data,timeout}", 40'({eng_start, eng_chan, eng_data, timeout}),
            40'({1'b1, 1'b0, 16'h0D0D, 1'b0}));
        next();
`else
        for (int k = 0; k < 19; k++) begin
            @(negedge clk_fast);
            chk($sformatf("long_wait%0d {busy,timeout,res0,res1,start}", k),
                40'({busy, timeout, res0_valid, res1_valid, eng_start}), 40'(5'b10000));
            next();
        end
        eng_done = 1'b1; eng_result = 16'hCAFE;
        @(negedge clk_fast);
        chk("long_done_cycle {busy,timeout}", 40'({busy, timeout}), 40'(2'b10));
        next();
        @(negedge clk_fast);
        chk("long_result {res0,res1,rdata,busy}", 40'({res0_valid, res1_valid, res_data, busy}),
            40'({1'b0, 1'b1, 16'hCAFE, 1'b0}));
        next();
        @(negedge clk_fast);
        chk("long_next_start {start,chan,data}", 40'({eng_start, eng_chan, eng_data}), 40'({1'b1, 1'b0, 16'h0D0D}));
        next();
`endif
        eng_done = 1'b1; eng_result = 16'h0DDD;
        next();
        @(negedge clk_fast);
        chk("final_result {res0,res1,rdata,timeout}", 40'({res0_valid, res1_valid, res_data, timeout}),
            40'({1'b1, 1'b0, 16'h0DDD, 1'b0}));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
